// File: rtl/booth_divider.sv
// booth_divider: sequential signed divider using restoring division on operand
// magnitudes, one iteration per clock, with sign correction in a final FIX cycle.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
// Optional feature macro: BOOTH_DIVIDER_DBZ_EN (zero-divisor detect, 1-edge result, dbz flag).
// dbg_state exposes the FSM state (0=IDLE 1=DIVIDE 2=FIX 3=DONE).
//
// Handshake: a start pulse sampled high at a rising edge loads dvd/dvs and
// drops ready. ready rises once quot/rem hold a valid result and stays high
// until the next start or reset. Asserting start again at any time discards
// the current division and restarts it with the new operands.
module booth_divider #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [w-1:0] dvd,
    input  logic [w-1:0] dvs,
    output logic [w-1:0] quot,
    output logic [w-1:0] rem,
    output logic         ready,
    output logic         dbz,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    localparam int CW = (w > 1) ? $clog2(w) : 1;
    localparam logic [CW-1:0] LAST = CW'(w - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [w-1:0]  dvs_mag_q;
    logic [w-1:0]  q_q;
    // Partial remainder is always below the divisor magnitude (<= 2^(w-1)),
    // so w stored bits suffice; the trial subtraction below runs at w+1 bits.
    logic [w-1:0]  r_q;
    logic          sign_q_q;
    logic          sign_r_q;
    logic [w-1:0]  quot_q;
    logic [w-1:0]  rem_q;
    logic          ready_q;
    logic          dbz_q;
`ifdef BOOTH_DIVIDER_DBZ_EN
    logic          zero_q;
    logic [w-1:0]  dvd_q;
`endif

    logic [w-1:0]  dvd_mag_d;
    logic [w-1:0]  dvs_mag_d;
    logic [w:0]    r_shift;
    logic [w:0]    r_trial;
    logic [w-1:0]  r_d;
    logic [w-1:0]  q_d;
    logic [w-1:0]  quot_fix_d;
    logic [w-1:0]  rem_fix_d;

    // Operand magnitudes, one restoring iteration, and the sign-corrected results.
    always_comb begin
        dvd_mag_d  = dvd[w-1] ? -dvd : dvd;
        dvs_mag_d  = dvs[w-1] ? -dvs : dvs;
        r_shift    = {r_q, q_q[w-1]};
        r_trial    = r_shift - {1'b0, dvs_mag_q};
        r_d        = r_trial[w-1:0];
        q_d        = {q_q[w-2:0], 1'b1};
        if (r_trial[w]) begin
            r_d = r_shift[w-1:0];
            q_d = {q_q[w-2:0], 1'b0};
        end
        quot_fix_d = sign_q_q ? -q_q : q_q;
        rem_fix_d  = sign_r_q ? -r_q : r_q;
    end

    // Divider FSM with registered outputs; start wins in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvs_mag_q <= '0;
            q_q       <= '0;
            r_q       <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            ready_q   <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef BOOTH_DIVIDER_DBZ_EN
            zero_q    <= 1'b0;
            dvd_q     <= '0;
`endif
        end else if (start) begin
            dvs_mag_q <= dvs_mag_d;
            q_q       <= dvd_mag_d;
            r_q       <= '0;
            cnt_q     <= '0;
            sign_q_q  <= dvd[w-1] ^ dvs[w-1];
            sign_r_q  <= dvd[w-1];
            quot_q    <= '0;
            rem_q     <= '0;
            ready_q   <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef BOOTH_DIVIDER_DBZ_EN
            zero_q    <= (dvs == '0);
            dvd_q     <= dvd;
            state_q   <= (dvs == '0) ? FIX : DIVIDE;
`else
            state_q   <= DIVIDE;
`endif
        end else begin
            case (state_q)
                DIVIDE: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
`ifdef BOOTH_DIVIDER_DBZ_EN
                    if (zero_q) begin
                        quot_q <= '1;
                        rem_q  <= dvd_q;
                        dbz_q  <= 1'b1;
                    end else begin
                        quot_q <= quot_fix_d;
                        rem_q  <= rem_fix_d;
                    end
`else
                    quot_q <= quot_fix_d;
                    rem_q  <= rem_fix_d;
`endif
                    ready_q <= 1'b1;
                    state_q <= DONE;
                end
                default: ;
            endcase
        end
    end

    assign quot      = quot_q;
    assign rem       = rem_q;
    assign ready     = ready_q;
    assign dbz       = dbz_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed self-checking bench for booth_divider at w=8.
module tb_booth_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] quot;
    logic [7:0] rem;
    logic       ready;
    logic       dbz;
    logic [1:0] dbg_state;

    int checks;
    int errors;

`ifdef BOOTH_DIVIDER_DBZ_EN
    localparam int  ZLAT = 1;
    localparam logic ZDBZ = 1'b1;
    localparam logic [7:0] ZQNEG = 8'hFF;
`else
    localparam int  ZLAT = 9;
    localparam logic ZDBZ = 1'b0;
    localparam logic [7:0] ZQNEG = 8'h01;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    booth_divider #(.w(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dvd(dvd), .dvs(dvs),
        .quot(quot), .rem(rem), .ready(ready), .dbz(dbz), .dbg_state(dbg_state)
    );

    // driver: one-cycle start pulse; returns at the negedge after the start edge
    task automatic do_start(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1; dvd = a; dvs = b;
        @(negedge clk);
        start = 1'b0; dvd = $urandom_range(0, 255); dvs = $urandom_range(0, 255);
    endtask

    // counts rising edges until ready, -1 on timeout; returns #1 after that edge
    task automatic wait_ready(input int first, output int edges);
        edges = -1;
        for (int i = first; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin edges = i; break; end
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({quot, rem, ready, dbz, dbg_state} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state got q=%h r=%h rdy=%b dbz=%b st=%0d want all 0",
                     quot, rem, ready, dbz, dbg_state);
        end
    endtask

    task automatic test_basic;
        int e;
        do_start(8'hF9, 8'h03);
        wait_ready(1, e);
        checks++;
        if (e !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", e); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (quot !== 8'hFE || rem !== 8'hFF || ready !== 1'b1 || dbz !== 1'b0) begin
                errors++;
                $display("FAIL basic_hold[%0d] got q=%h r=%h rdy=%b dbz=%b want q=fe r=ff rdy=1 dbz=0",
                         k, quot, rem, ready, dbz);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_signs;
        int e;
        logic [7:0] ta [6] = '{8'd100, 8'h9C, 8'h80, 8'd5, 8'd50, 8'd81};
        logic [7:0] tb [6] = '{8'hF9, 8'hF9, 8'hFF, 8'd9, 8'd7, 8'd9};
        logic [7:0] tq [6] = '{8'hF2, 8'h0E, 8'h80, 8'h00, 8'd7, 8'd9};
        logic [7:0] tr [6] = '{8'h02, 8'hFE, 8'h00, 8'h05, 8'd1, 8'd0};
        for (int k = 0; k < 6; k++) begin
            do_start(ta[k], tb[k]);
            wait_ready(1, e);
            checks++;
            if (e !== 9 || quot !== tq[k] || rem !== tr[k] || dbz !== 1'b0) begin
                errors++;
                $display("FAIL signs[%0d] got lat=%0d q=%h r=%h dbz=%b want lat=9 q=%h r=%h dbz=0",
                         k, e, quot, rem, dbz, tq[k], tr[k]);
            end
        end
    endtask

    task automatic test_zero_div;
        int e;
        do_start(8'd37, 8'd0);
        wait_ready(1, e);
        checks++;
        if (e !== ZLAT || quot !== 8'hFF || rem !== 8'd37 || dbz !== ZDBZ) begin
            errors++;
            $display("FAIL zero_pos got lat=%0d q=%h r=%h dbz=%b want lat=%0d q=ff r=25 dbz=%b",
                     e, quot, rem, dbz, ZLAT, ZDBZ);
        end
        do_start(8'hDB, 8'd0);
        checks++;
        if (dbz !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_clear got dbz=%b rdy=%b want 0 0", dbz, ready);
        end
        wait_ready(1, e);
        checks++;
        if (e !== ZLAT || quot !== ZQNEG || rem !== 8'hDB || dbz !== ZDBZ) begin
            errors++;
            $display("FAIL zero_neg got lat=%0d q=%h r=%h dbz=%b want lat=%0d q=%h r=db dbz=%b",
                     e, quot, rem, dbz, ZLAT, ZQNEG, ZDBZ);
        end
    endtask

    task automatic test_async_reset;
        int e;
        // reset while a result is held clears outputs without a clock edge
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        checks++;
        if ({quot, rem, ready, dbz, dbg_state} !== 20'h0) begin
            errors++;
            $display("FAIL reset_done got q=%h r=%h rdy=%b dbz=%b st=%0d want all 0",
                     quot, rem, ready, dbz, dbg_state);
        end
        @(negedge clk); rst_n = 1'b1;
        // reset during the 4th DIVIDE cycle aborts the division
        do_start(8'd50, 8'd7);
        repeat (3) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        checks++;
        if ({quot, rem, ready, dbg_state} !== 19'h0) begin
            errors++;
            $display("FAIL reset_mid got q=%h r=%h rdy=%b st=%0d want all 0",
                     quot, rem, ready, dbg_state);
        end
        @(negedge clk); rst_n = 1'b1;
        wait_ready(1, e);
        checks++;
        if (e !== -1 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_abort got ready_edge=%0d st=%0d want -1 0", e, dbg_state);
        end
        do_start(8'd50, 8'd7);
        wait_ready(1, e);
        checks++;
        if (e !== 9 || quot !== 8'd7 || rem !== 8'd1) begin
            errors++;
            $display("FAIL reset_after got lat=%0d q=%h r=%h want 9 07 01", e, quot, rem);
        end
    endtask

    task automatic test_back_to_back;
        int e;
        do_start(8'd50, 8'd7);
        @(negedge clk);   // edges 1 and 2 done; restart lands on edge 3
        do_start(8'd81, 8'd9);
        wait_ready(1, e);
        checks++;
        if (e !== 9 || quot !== 8'd9 || rem !== 8'd0) begin
            errors++;
            $display("FAIL restart got lat=%0d q=%h r=%h want 9 09 00", e, quot, rem);
        end
        // start held high keeps reloading
        @(negedge clk);
        start = 1'b1; dvd = 8'h9C; dvs = 8'h03;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || dbg_state !== 2'd1) begin
                errors++;
                $display("FAIL start_held[%0d] got rdy=%b st=%0d want 0 1", k, ready, dbg_state);
            end
        end
        start = 1'b0;
        wait_ready(1, e);
        checks++;
        if (e !== 9 || quot !== 8'hDF || rem !== 8'hFF) begin
            errors++;
            $display("FAIL start_release got lat=%0d q=%h r=%h want 9 df ff", e, quot, rem);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; dvd = '0; dvs = '0;
        #12;
        test_reset;
        @(negedge clk); rst_n = 1'b1;
        test_basic;
        test_signs;
        test_zero_div;
        test_async_reset;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
